// File: rtl/mem_responder.sv
// Memory-side responder: samples a CPU read/write request, waits WAIT_STATES cycles, accesses a
// word array and completes with a four-phase ready handshake. Optional MEM_OOR_ERR_EN flags errors.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_wr_q, op_wr_d;
  logic                  xfer_err_q, xfer_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                       accept;
  logic                       req_err;
  logic [ADDR_WIDTH-1:IdxW]   addr_hi;

  assign addr_hi = addr[ADDR_WIDTH-1:IdxW];

`ifdef MEM_OOR_ERR_EN
  // Both-high requests become error transfers; DEPTH is a power of two, so any high bit is OOR.
  assign accept  = mem_rd | mem_wr;
  assign req_err = (mem_rd & mem_wr) | (|addr_hi);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_hi;
  assign accept         = mem_rd ^ mem_wr;
  assign req_err        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    xfer_err_d = xfer_err_q;
    rd_data_d  = rd_data_q;
    ready_d    = ready_q;
    err_d      = err_q;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d      = addr[IdxW-1:0];
          wdata_d    = wr_data;
          op_wr_d    = mem_wr & ~mem_rd;
          xfer_err_d = req_err;
          if (WAIT_STATES == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAccess: begin
        ready_d = 1'b1;
        err_d   = xfer_err_q;
        state_d = StDone;
        if (xfer_err_q) begin
          if (!op_wr_q) rd_data_d = '0;
        end else if (op_wr_q) begin
          mem_we = ~rst;
        end else begin
          rd_data_d = mem_q[idx_q];
        end
      end
      StDone: begin
        // A held request parks here so it is never serviced twice.
        if (!mem_rd && !mem_wr) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      xfer_err_q <= 1'b0;
      rd_data_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      op_wr_q    <= op_wr_d;
      xfer_err_q <= xfer_err_d;
      rd_data_q  <= rd_data_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign rd_data = rd_data_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        ready, busy, err;

  logic        rd_z, wr_z;
  logic [31:0] addr_z, wdata_z, rdata_z;
  logic        ready_z, busy_z, err_z;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (1024),
    .WAIT_STATES(2)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .mem_rd (rd),
    .mem_wr (wr),
    .addr   (addr),
    .wr_data(wdata),
    .rd_data(rdata),
    .ready  (ready),
    .busy   (busy),
    .err    (err)
  );

  mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (1024),
    .WAIT_STATES(0)
  ) u_dut_z (
    .clk    (clk),
    .rst    (rst),
    .mem_rd (rd_z),
    .mem_wr (wr_z),
    .addr   (addr_z),
    .wr_data(wdata_z),
    .rd_data(rdata_z),
    .ready  (ready_z),
    .busy   (busy_z),
    .err    (err_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic release_req(input string tag);
    rd = 1'b0;
    wr = 1'b0;
    tick();
    chk({tag, "_ready_fall"}, {31'd0, ready}, 32'd0);
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err_clear"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start(1'b0, 1'b0, 32'd0, 32'd0);
    rd_z    = 1'b0;
    wr_z    = 1'b0;
    addr_z  = 32'd0;
    wdata_z = 32'd0;
    repeat (2) tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write 0xDEADBEEF to 5: ready on the third edge after sampling.
    start(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
    tick();
    chk("wr5_busy", {31'd0, busy}, 32'd1);
    chk("wr5_ready_e0", {31'd0, ready}, 32'd0);
    tick();
    chk("wr5_ready_e1", {31'd0, ready}, 32'd0);
    tick();
    chk("wr5_ready_e2", {31'd0, ready}, 32'd0);
    tick();
    chk("wr5_ready_e3", {31'd0, ready}, 32'd1);
    chk("wr5_err", {31'd0, err}, 32'd0);
    chk("wr5_rdata_untouched", rdata, 32'd0);
    release_req("wr5");

    // Read 5, changing addr after sampling; then hold the request for 10 cycles.
    start(1'b1, 1'b0, 32'd5, 32'd0);
    tick();
    addr = 32'd9;
    repeat (3) tick();
    chk("rd5_ready", {31'd0, ready}, 32'd1);
    chk("rd5_rdata", rdata, 32'hDEADBEEF);
    repeat (5) tick();
    chk("hold_ready_mid", {31'd0, ready}, 32'd1);
    repeat (5) tick();
    chk("hold_ready_end", {31'd0, ready}, 32'd1);
    chk("hold_busy_end", {31'd0, busy}, 32'd1);
    chk("hold_rdata", rdata, 32'hDEADBEEF);
    release_req("hold");

    // Old value at 7, then reset during the WAIT of an overwrite.
    start(1'b0, 1'b1, 32'd7, 32'h11112222);
    repeat (4) tick();
    chk("wr7_ready", {31'd0, ready}, 32'd1);
    release_req("wr7");
    start(1'b0, 1'b1, 32'd7, 32'h12345678);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    wr = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    start(1'b1, 1'b0, 32'd7, 32'd0);
    repeat (4) tick();
    chk("rd7_ready", {31'd0, ready}, 32'd1);
    chk("rd7_old_value", rdata, 32'h11112222);
    release_req("rd7");

    // Both requests high in IDLE.
    start(1'b1, 1'b1, 32'd5, 32'h0BADF00D);
    repeat (4) tick();
`ifdef MEM_OOR_ERR_EN
    chk("both_ready", {31'd0, ready}, 32'd1);
    chk("both_err", {31'd0, err}, 32'd1);
    release_req("both");
`else
    chk("both_ready", {31'd0, ready}, 32'd0);
    chk("both_busy", {31'd0, busy}, 32'd0);
    rd = 1'b0;
    wr = 1'b0;
    tick();
`endif
    start(1'b1, 1'b0, 32'd5, 32'd0);
    repeat (4) tick();
    chk("both_array_unchanged", rdata, 32'hDEADBEEF);
    release_req("rd5b");

    // Out-of-range read of DEPTH + 3.
    start(1'b0, 1'b1, 32'd3, 32'hCAFE0003);
    repeat (4) tick();
    release_req("wr3");
    start(1'b1, 1'b0, 32'd1027, 32'd0);
    repeat (4) tick();
    chk("oor_ready", {31'd0, ready}, 32'd1);
`ifdef MEM_OOR_ERR_EN
    chk("oor_rdata", rdata, 32'd0);
    chk("oor_err", {31'd0, err}, 32'd1);
`else
    chk("oor_rdata", rdata, 32'hCAFE0003);
    chk("oor_err", {31'd0, err}, 32'd0);
`endif
    release_req("oor");

    // WAIT_STATES = 0 instance: one-edge latency, back-to-back write then read.
    wr_z    = 1'b1;
    addr_z  = 32'd12;
    wdata_z = 32'hA5A5A5A5;
    tick();
    chk("z_wr_busy", {31'd0, busy_z}, 32'd1);
    chk("z_wr_ready_e0", {31'd0, ready_z}, 32'd0);
    tick();
    chk("z_wr_ready_e1", {31'd0, ready_z}, 32'd1);
    wr_z = 1'b0;
    tick();
    chk("z_wr_ready_fall", {31'd0, ready_z}, 32'd0);
    chk("z_wr_busy_fall", {31'd0, busy_z}, 32'd0);
    rd_z = 1'b1;
    tick();
    tick();
    chk("z_rd_ready", {31'd0, ready_z}, 32'd1);
    chk("z_rd_rdata", rdata_z, 32'hA5A5A5A5);
    chk("z_rd_err", {31'd0, err_z}, 32'd0);
    rd_z = 1'b0;
    tick();
    chk("z_rd_ready_fall", {31'd0, ready_z}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU's memory request interface. It samples a read or write request (mem_rd / mem_wr, address from the MAR side, data from the MDR side) and accesses an internal word-addressed storage array after a programmable number of wait states. It completes the transfer with a four-phase ready handshake and returns read data on a registered output. It sits between the cpu top level and the testbench/system top.

Parameters:
ADDR_WIDTH, 32, width of the address input.
DATA_WIDTH, 32, word width of the storage array and data ports.
DEPTH, 1024, number of words in the array; must be a power of two.
WAIT_STATES, 2, number of idle cycles inserted between request sample and access (0 allowed).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
mem_rd  input  1  read request; held by the requester until ready is seen.
mem_wr  input  1  write request; held by the requester until ready is seen.
addr  input  ADDR_WIDTH  word address, sampled with the request.
wr_data  input  DATA_WIDTH  write data, sampled with the request.
rd_data  output  DATA_WIDTH  registered read data.
ready  output  1  transfer complete; held until the request drops.
busy  output  1  high in every state except IDLE.
err  output  1  access error flag, valid while ready is high.

Behaviour:
- Reset (async, any state, including mid-transfer):
  - state = IDLE; ready = 0, busy = 0, err = 0, rd_data = 0, wait counter = 0.
  - Storage array contents are not cleared.
  - A pending write is discarded and the array is not modified.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If exactly one of mem_rd or mem_wr is high at an edge, the responder latches addr, wr_data and the operation type.
  - It then goes to WAIT with the counter set to WAIT_STATES, or directly to ACCESS if WAIT_STATES == 0.
  - If mem_rd and mem_wr are both high, the request is ignored and the FSM stays in IDLE.
- WAIT: the counter decrements each edge. When the counter would reach 0, the FSM moves to ACCESS.
- ACCESS: lasts exactly one cycle. At its ending edge:
  - Write: mem[idx] <= latched wr_data.
  - Read: rd_data <= mem[idx].
  - ready <= 1; state <= DONE.
- DONE:
  - ready stays 1.
  - When both mem_rd and mem_wr are low at an edge: ready <= 0, err <= 0, state <= IDLE.
  - Any request still high holds the FSM in DONE, so a held request cannot be serviced twice.
- Latency: with the request sampled at edge N, ready rises at edge N + WAIT_STATES + 1. A new request can be sampled no earlier than the edge after the one that returns the FSM to IDLE.
- Input stability: addr, wr_data and the request level are ignored after sampling. Changes during WAIT or ACCESS have no effect.
- rd_data holds its value until the next completed read; writes do not change it.
- Address index: idx = addr mod DEPTH (low log2(DEPTH) bits) unless the optional feature overrides this.
- busy = (state != IDLE), registered alongside state.

Optional Feature:
Macro MEM_OOR_ERR_EN.
- Defined:
  - An address with addr >= DEPTH is out of range.
  - Out-of-range write: the array is untouched.
  - Out-of-range read: rd_data <= 0.
  - err <= 1 on the same edge as ready, held through DONE.
  - A both-high request in IDLE is accepted as an error transfer: no array access, err = 1, normal WAIT_STATES latency.
- Not defined: addresses wrap modulo DEPTH, a both-high request is ignored, and err is tied to 0.

Test Plan:
- Basic write/read (WAIT_STATES = 2):
  - Write 0xDEADBEEF to addr 5: ready rises 3 edges after sample; drop mem_wr and ready falls on the next edge.
  - Read addr 5: rd_data = 0xDEADBEEF when ready rises.
- Held request: keep mem_rd high for 10 cycles after ready. Expect ready to stay 1, exactly one read, FSM in DONE; release gives IDLE one edge later.
- Reset mid-write: rst pulse during WAIT of a write of 0x12345678 to addr 7. Expect all outputs 0, state IDLE, and a read of addr 7 returns its old value.
- WAIT_STATES = 0 build: ready 1 edge after sample; a back-to-back read of the same address returns the just-written data.
- Both requests high in IDLE:
  - Without the macro: no ready, busy stays 0.
  - With MEM_OOR_ERR_EN: ready and err both 1 after WAIT_STATES + 1 edges, and the array is unchanged.
- Out-of-range read of addr DEPTH + 3 (DEPTH = 1024):
  - With MEM_OOR_ERR_EN: rd_data = 0, err = 1.
  - Without: returns the word at addr 3.
